// File: rtl/block_transfer_seq.sv
// block_transfer_seq: LDM/STM-style multi-register transfer sequencer.
// Walks the latched register list lowest index first. Stores read the register
// file and write memory. Loads write the register file from memory read data.
// An optional single-cycle base writeback follows the last access.
module block_transfer_seq #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_load,
  input  logic [NREG-1:0] reg_list,
  input  logic [DW-1:0]   base,
  input  logic [AW-1:0]   base_reg,
  input  logic            up,
  input  logic            pre,
  input  logic            wback,
  output logic [AW-1:0]   ra,
  input  logic [DW-1:0]   rd_data,
  output logic [AW-1:0]   wa,
  output logic [DW-1:0]   wd,
  output logic            we,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_req,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, XFER, WBACK, DONE} state_t;

  localparam int CW = $clog2(NREG + 1);

  state_t          state, state_nx;
  logic            ld_q, wb_q, base_hit_q;
  logic [NREG-1:0] list_q, list_clr;
  logic [AW-1:0]   base_reg_q, cur;
  logic [DW-1:0]   addr_q, final_q, span, first_addr;
  logic [CW-1:0]   n_cnt;

  // Population count of the incoming list; the block spans 4*N bytes.
  always_comb begin
    n_cnt = '0;
    for (int i = 0; i < NREG; i++) n_cnt = n_cnt + CW'(reg_list[i]);
  end

  assign span = DW'(n_cnt) << 2;

  // Accesses always run upward from the lowest address of the block, so only
  // the starting point depends on up/pre.
  assign first_addr = up ? (pre ? base + DW'(4) : base)
                         : (pre ? base - span : base - span + DW'(4));

  // Current register: lowest set bit of what remains of the list.
  always_comb begin
    cur = '0;
    for (int i = NREG - 1; i >= 0; i--) if (list_q[i]) cur = AW'(i);
  end

  // Remaining list with the current (lowest) bit cleared.
  assign list_clr = list_q & (list_q - NREG'(1));

  // State register plus operands latched at start and advanced per access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ld_q       <= 1'b0;
      wb_q       <= 1'b0;
      base_hit_q <= 1'b0;
      list_q     <= '0;
      base_reg_q <= '0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        ld_q       <= is_load;
        wb_q       <= wback;
        base_hit_q <= reg_list[base_reg];
        list_q     <= reg_list;
        base_reg_q <= base_reg;
        addr_q     <= first_addr;
        final_q    <= up ? base + span : base - span;
      end else if (state == XFER && mem_ready) begin
        list_q <= list_clr;
        addr_q <= addr_q + DW'(4);
      end
    end
  end

  // Next state and datapath port takeover; everything idles at zero.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    ra        = '0;
    wa        = '0;
    wd        = '0;
    we        = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (reg_list == '0) ? DONE : XFER;
      XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (!ld_q) begin
          ra        = cur;
          mem_we    = 1'b1;
          mem_wdata = rd_data;
        end else if (mem_ready) begin
          we = 1'b1;
          wa = cur;
          wd = mem_rdata;
        end
        if (mem_ready && list_clr == '0) state_nx = wb_q ? WBACK : DONE;
      end
      WBACK: begin
        busy     = 1'b1;
        wa       = base_reg_q;
        wd       = final_q;
        // a load that also targets the base register keeps the loaded value
        we       = !(ld_q && base_hit_q);
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_seq.sv
// Testbench for block_transfer_seq: register file and memory models around the
// DUT, a directed vector table, stall/reset sequences and randomized transfers
// checked against expected contents computed from the transfer rules.
module tb_block_transfer_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, is_load = 1'b0;
  logic        up = 1'b0, pre = 1'b0, wback = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base = '0;
  logic [3:0]  base_reg = '0;
  logic [3:0]  ra, wa;
  logic [31:0] rd_data, wd, mem_addr, mem_wdata, mem_rdata;
  logic        we, mem_req, mem_we, busy, done;
  logic        mem_ready = 1'b1;

  logic [31:0] rf  [16];
  logic [31:0] mem [256];
  int          acc_cnt = 0, we_cnt = 0, proto_err = 0;
  int          ready_mode = 0, stall_at = -1, stall_used = 0;
  logic        poke_en = 1'b0, poke_mem = 1'b0;
  logic [31:0] poke_a = '0, poke_v = '0;
  int          errors = 0, checks = 0;

  block_transfer_seq #(.NREG(16), .AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base(base), .base_reg(base_reg), .up(up), .pre(pre), .wback(wback),
    .ra(ra), .rd_data(rd_data), .wa(wa), .wd(wd), .we(we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rd_data   = rf[ra];
  assign mem_rdata = mem[mem_addr[9:2]];

  // Register file / memory update, plus access and write counters.
  always @(posedge clk) begin
    if (poke_en) begin
      if (poke_mem) mem[poke_a[9:2]] <= poke_v;
      else          rf[poke_a[3:0]]  <= poke_v;
    end
    if (we) begin
      rf[wa] <= wd;
      we_cnt <= we_cnt + 1;
    end
    if (mem_req && mem_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Memory handshake: always ready, random stalls, or three stalls on one access.
  always @(posedge clk) begin
    #2;
    if (ready_mode == 2 && acc_cnt == stall_at && stall_used < 3) begin
      mem_ready = 1'b0;
      stall_used++;
    end else begin
      mem_ready = (ready_mode == 1) ? ($urandom_range(0, 99) >= 30) : 1'b1;
      if (acc_cnt != stall_at) stall_used = 0;
    end
  end

  // Protocol watch: no store/write overlap, load writes only with ready,
  // request held stable through stalls, store data is the read-port value.
  logic        prev_stall = 1'b0, prev_mwe = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [3:0]  prev_ra = '0;
  always @(negedge clk) begin
    if (!rst_n) prev_stall <= 1'b0;
    else begin
      if ((mem_req && mem_we && we) || (we && mem_req && !mem_ready) ||
          (mem_req && mem_we && mem_wdata !== rf[ra]) ||
          (prev_stall && (!mem_req || mem_addr != prev_addr || ra != prev_ra || mem_we != prev_mwe)))
        proto_err <= proto_err + 1;
      prev_stall <= mem_req && !mem_ready;
      prev_addr  <= mem_addr;
      prev_ra    <= ra;
      prev_mwe   <= mem_we;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic m, input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    poke_en = 1'b1; poke_mem = m; poke_a = a; poke_v = v;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One transfer: compute expected register/memory contents, run the DUT with
  // start held (and operands scrambled) while busy, then compare.
  task automatic run(input logic ld, input logic [15:0] lst, input logic [31:0] b,
                     input logic [3:0] br, input logic u, input logic p, input logic wb,
                     output int cyc, output logic [31:0] first);
    logic [31:0] erf [16];
    logic [31:0] emem [256];
    logic [31:0] a, fin;
    int n, exp_we, acc0, we0, busy_cyc, bad;
    logic got;
    erf = rf; emem = mem;
    n   = $countones(lst);
    fin = u ? b + 32'(4 * n) : b - 32'(4 * n);
    // lowest address of the block; registers map upward from it
    a = u ? b + (p ? 32'd4 : 32'd0) : b - 32'(4 * n) + (p ? 32'd0 : 32'd4);
    for (int i = 0; i < 16; i++) if (lst[i]) begin
      if (ld) erf[i] = mem[a[9:2]];
      else    emem[a[9:2]] = rf[i];
      a = a + 32'd4;
    end
    exp_we = ld ? n : 0;
    if (wb && n > 0 && !(ld && lst[br])) begin
      erf[br] = fin;
      exp_we++;
    end

    @(negedge clk);
    start = 1'b1; is_load = ld; reg_list = lst; base = b; base_reg = br;
    up = u; pre = p; wback = wb;
    acc0 = acc_cnt; we0 = we_cnt;
    @(posedge clk);
    cyc = 0; got = 1'b0; first = '0; busy_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (mem_req && !got) begin got = 1'b1; first = mem_addr; end
      is_load = 1'($urandom); reg_list = 16'($urandom); base = $urandom;
      base_reg = 4'($urandom); up = 1'($urandom); pre = 1'($urandom); wback = 1'($urandom);
    end while (!done && cyc < 300);
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);  // start still high across the DONE exit edge
    start = 1'b0;
    @(negedge clk);
    chk("idle_after", 32'({busy, mem_req, we}), 32'd0);
    chk("busy_cycles", busy_cyc, cyc - 1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (rf[i] !== erf[i]) bad++;
    chk("rf_state_bad_regs", bad, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== emem[i]) bad++;
    chk("mem_state_bad_words", bad, 0);
    chk("mem_accesses", acc_cnt - acc0, n);
    chk("rf_writes", we_cnt - we0, exp_we);
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] lst;
    logic [31:0] b;
    logic [3:0]  br;
    logic        u, p, wb;
    int          cyc;
    logic [31:0] first;
    logic        k0;  logic [31:0] a0, v0;  // check 0: k=1 memory word, k=0 register
    logic        k1;  logic [31:0] a1, v1;
  } vec_t;

  vec_t        vt [7];
  int          cyc, snap_acc, snap_we;
  logic [31:0] first, got_v;

  initial begin
    // reset state
    #1;
    chk("reset_outputs", 32'(|{ra, wa, wd, mem_addr, mem_wdata, mem_req, mem_we, we, busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) poke(1'b0, 32'(i), 32'(i * 'h11));
    poke(1'b1, 32'h1F8, 32'hAA); poke(1'b1, 32'h1FC, 32'hBB);
    poke(1'b1, 32'h140, 32'hC1); poke(1'b1, 32'h144, 32'hC2);

    //        ld   list      base          br  u  p  wb cyc first         k a0        v0          k a1        v1
    vt[0] = '{1'b0, 16'h000E, 32'h100,      13, 1, 0, 1, 5, 32'h100,      1, 32'h104, 32'h22,     0, 13,        32'h10C};
    vt[1] = '{1'b1, 16'h8001, 32'h200,      13, 0, 1, 1, 4, 32'h1F8,      0, 15,        32'hBB,     0, 13,        32'h1F8};
    vt[2] = '{1'b1, 16'h0006, 32'h140,      2,  1, 0, 1, 4, 32'h140,      0, 2,         32'hC2,     0, 1,         32'hC1};
    vt[3] = '{1'b0, 16'h0003, 32'h300,      5,  0, 0, 0, 3, 32'h2FC,      1, 32'h2FC, 32'hAA,     1, 32'h300, 32'hC1};
    vt[4] = '{1'b0, 16'h0000, 32'h240,      13, 1, 0, 1, 1, 32'h0,        0, 13,        32'h1F8,    0, 4,         32'h44};
    vt[5] = '{1'b0, 16'h0010, 32'hFFFFFFFC, 6,  1, 1, 1, 3, 32'h0,        1, 32'h0,   32'h44,     0, 6,         32'h0};
    vt[6] = '{1'b0, 16'h2008, 32'h280,      13, 0, 1, 1, 4, 32'h278,      1, 32'h27C, 32'h1F8,    0, 13,        32'h278};

    for (int t = 0; t < 7; t++) begin
      run(vt[t].ld, vt[t].lst, vt[t].b, vt[t].br, vt[t].u, vt[t].p, vt[t].wb, cyc, first);
      chk($sformatf("vec%0d_cycles", t), cyc, vt[t].cyc);
      chk($sformatf("vec%0d_first_addr", t), first, vt[t].first);
      got_v = vt[t].k0 ? mem[vt[t].a0[9:2]] : rf[vt[t].a0[3:0]];
      chk($sformatf("vec%0d_val0", t), got_v, vt[t].v0);
      got_v = vt[t].k1 ? mem[vt[t].a1[9:2]] : rf[vt[t].a1[3:0]];
      chk($sformatf("vec%0d_val1", t), got_v, vt[t].v1);
    end

    // three-cycle stall on the second access of a load
    stall_at = acc_cnt + 1; ready_mode = 2;
    run(1'b1, 16'h0007, 32'h100, 4'd0, 1'b1, 1'b0, 1'b0, cyc, first);
    ready_mode = 0; stall_at = -1;
    chk("stall_cycles", cyc, 7);
    chk("stall_r0", rf[0], 32'h11);
    chk("stall_r2", rf[2], 32'h33);

    // reset in the middle of a 4-register load, after the first transfer
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; reg_list = 16'h00F0; base = 32'h100; base_reg = 4'd0;
    up = 1'b1; pre = 1'b0; wback = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'(|{ra, wa, wd, mem_addr, mem_wdata, mem_req, mem_we, we, busy, done}), 32'd0);
    snap_acc = acc_cnt; snap_we = we_cnt;
    repeat (2) @(negedge clk);
    chk("reset_no_access", acc_cnt - snap_acc, 0);
    chk("reset_no_write", we_cnt - snap_we, 0);
    chk("reset_first_xfer_r4", rf[4], 32'h11);
    #1 rst_n = 1'b1;
    run(1'b1, 16'h00F0, 32'h100, 4'd0, 1'b1, 1'b0, 1'b1, cyc, first);
    chk("post_reset_cycles", cyc, 6);

    // randomized transfers with random memory stalls
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      logic [15:0] l;
      l = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run(1'($urandom), l, 32'h100 + 32'(4 * $urandom_range(0, 128)), 4'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), cyc, first);
    end
    ready_mode = 0;

    chk("protocol_violations", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_transfer_seq.md
Name: block_transfer_seq

Overview:
Multi-register transfer sequencer for LDM/STM-style instructions. It walks a 16-bit register list in ascending order. For stores it drives the register file read port and the data memory write side. For loads it drives the register file write port (A3/WD3/WE3 style) from memory read data. It optionally writes the updated base back, and sits beside the register file in the datapath, taking over its ports while busy.

Parameters:
NREG, 16, number of architectural registers (list width)
AW, 4, register index width
DW, 32, data and address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin transfer; sampled only in IDLE
is_load  in  1  1 = load (memory to registers), 0 = store
reg_list  in  NREG  registers to transfer, bit i = register i
base  in  DW  base address value
base_reg  in  AW  index of base register, used for writeback
up  in  1  1 = increment, 0 = decrement
pre  in  1  1 = adjust address before each access (IB/DB), 0 = after (IA/DA)
wback  in  1  write the final base into base_reg
ra  out  AW  register file read address
rd_data  in  DW  register file read data (combinational from ra)
wa  out  AW  register file write address
wd  out  DW  register file write data
we  out  1  register file write enable
mem_addr  out  DW  memory word address
mem_wdata  out  DW  memory write data (= rd_data)
mem_req  out  1  memory request
mem_we  out  1  1 = write request
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  request accepted/completed this cycle
busy  out  1  high from the cycle after start acceptance until DONE exits
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including ra, wa, wd, mem_addr. Pending list cleared. No write issued after reset assertion, even mid-transfer.
- States: IDLE, XFER, WBACK, DONE.
- IDLE: on start=1, latch all inputs; N = popcount(reg_list).
  - N=0: go to DONE; no memory access, no writeback.
  - Otherwise: go to XFER.
- First address is computed from the latched inputs:
  - IA: base
  - IB: base+4
  - DA: base-4N+4
  - DB: base-4N
- Accesses always go lowest register to highest; the address increments by 4 per access regardless of up.
- Final base value: up ? base+4N : base-4N, modulo 2^DW (wrap-around permitted).
- XFER: cur = lowest set bit of the remaining list.
  - mem_req=1 and mem_addr held stable until mem_ready.
  - Store: ra=cur, mem_we=1, mem_wdata=rd_data.
  - Load: mem_we=0. In the mem_ready cycle: we=1, wa=cur, wd=mem_rdata (combinational).
  - On mem_ready: clear bit cur and advance the address by 4. If the list becomes empty, go to WBACK if wback, else DONE.
  - mem_ready=0: stall with all outputs stable; no we.
- WBACK (1 cycle): we=1, wa=base_reg, wd=final base.
  - Exception: load with base_reg in reg_list. Writeback is suppressed (we=0) and the loaded value wins.
  - Store with base_reg in list: the stored value is the original register value (base not yet updated).
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. The next start can be accepted in the IDLE cycle right after.
- start while busy or in DONE: ignored, no queuing.
- Latency with mem_ready tied 1 (start sampled at edge k):
  - XFER occupies cycles k+1..k+N.
  - WBACK at k+N+1 when wback=1.
  - done in the next cycle.
- Register 15 is transferred like any other index; no special PC handling.
- we and mem_req are never both asserted for a store. For a load, we asserts only together with mem_ready.

Test Plan:
- STM IA, list=0x000E, base=0x100, wback=1, regs r1..r3=0x11,0x22,0x33, ready=1 -> writes 0x11@0x100, 0x22@0x104, 0x33@0x108; WBACK writes base_reg=0x10C; done at cycle 5 after start.
- LDM DB, list=0x8001, base=0x200, memory 0x1F8=0xAA, 0x1FC=0xBB -> r0=0xAA, r15=0xBB; writeback value 0x1F8.
- LDM IA, base_reg=2, list=0x0006, wback=1 -> r1, r2 loaded from memory; no WBACK write; r2 keeps the loaded value.
- mem_ready low for 3 cycles on the second access -> mem_addr/ra held stable, we=0 during the stall, sequence resumes, total latency +3.
- list=0x0000 with start -> no mem_req, no we, done pulse the cycle after start; start again while busy ignored.
- rst_n asserted mid-XFER after 1 of 4 transfers -> outputs 0 immediately, no further we/mem_req; new start after release runs the full sequence.
